// File: rtl/async_fifo_if.sv
// Handshake and data bundle for the FIFO: write side, read side and status.
// The master modport is the user of the FIFO; the slave modport is the FIFO itself.
interface async_fifo_if #(
  parameter int DSIZE = 8,
  parameter int ASIZE = 3
);
  logic             winc;
  logic [DSIZE-1:0] wdata;
  logic             wfull;
  logic             rinc;
  logic [DSIZE-1:0] rdata;
  logic             rempty;
  logic [ASIZE:0]   count;

  modport master (
    output winc, wdata, rinc,
    input  wfull, rdata, rempty, count
  );

  modport slave (
    input  winc, wdata, rinc,
    output wfull, rdata, rempty, count
  );
endinterface

// File: rtl/async_fifo.sv
// Single-clock FIFO with binary wrap pointers and registered status.
// Pointers carry one extra MSB so that full and empty are told apart without
// a separate counter. The flags and count are computed from the next-state
// pointers, so they change on the same edge as the accepted operations.
module async_fifo #(
  parameter int DSIZE = 8,
  parameter int ASIZE = 3
) (
  input  logic        clk,
  input  logic        rst,
  async_fifo_if.slave bus
);
  localparam int DEPTH = 1 << ASIZE;

  logic [DSIZE-1:0] mem [DEPTH];

  logic [ASIZE:0]   wptr_q, wptr_d;
  logic [ASIZE:0]   rptr_q, rptr_d;
  logic [ASIZE:0]   count_q, count_d;
  logic             wfull_q, wfull_d;
  logic             rempty_q, rempty_d;
  logic [DSIZE-1:0] rdata_q, rdata_d;
  logic             wr_en, rd_en;

  // Accept decisions and next-state pointers, flags, count and read data.
  always_comb begin
    wr_en    = bus.winc & ~wfull_q;
    rd_en    = bus.rinc & ~rempty_q;
    wptr_d   = wptr_q + {{ASIZE{1'b0}}, wr_en};
    rptr_d   = rptr_q + {{ASIZE{1'b0}}, rd_en};
    // Modulo subtraction of the wrap pointers yields 0..DEPTH directly.
    count_d  = wptr_d - rptr_d;
    wfull_d  = (wptr_d ^ rptr_d) == {1'b1, {ASIZE{1'b0}}};
    rempty_d = (wptr_d == rptr_d);
    rdata_d  = rdata_q;
    if (rd_en) begin
      rdata_d = mem[rptr_q[ASIZE-1:0]];
    end
  end

  // Control and output registers; reset empties the FIFO in one edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q   <= '0;
      rptr_q   <= '0;
      count_q  <= '0;
      wfull_q  <= 1'b0;
      rempty_q <= 1'b1;
      rdata_q  <= '0;
    end else begin
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      count_q  <= count_d;
      wfull_q  <= wfull_d;
      rempty_q <= rempty_d;
      rdata_q  <= rdata_d;
    end
  end

  // Storage array; left uncleared since reset makes old contents unreachable.
  always_ff @(posedge clk) begin
    if (!rst && wr_en) begin
      mem[wptr_q[ASIZE-1:0]] <= bus.wdata;
    end
  end

  assign bus.wfull  = wfull_q;
  assign bus.rempty = rempty_q;
  assign bus.count  = count_q;
  assign bus.rdata  = rdata_q;
endmodule

// File: tb/tb_async_fifo.sv
// Scoreboard bench for async_fifo: a queue-based reference model predicts
// each cycle's status and read data; a monitor compares after every edge.
module tb_async_fifo;
  localparam int DSIZE = 8;
  localparam int ASIZE = 3;
  localparam int DEPTH = 1 << ASIZE;

  typedef struct {
    bit rst;
    bit rd;
    int cnt;
    bit full;
    bit empty;
  } rec_t;

  logic clk = 1'b0;
  logic rst = 1'b0;

  async_fifo_if #(.DSIZE(DSIZE), .ASIZE(ASIZE)) bus ();

  async_fifo #(.DSIZE(DSIZE), .ASIZE(ASIZE)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  logic [DSIZE-1:0] model_q [$];
  logic [DSIZE-1:0] dat_q   [$];
  rec_t             st_q    [$];

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // One cycle of stimulus, driven on the falling edge; the model predicts
  // the outcome of the following rising edge.
  task automatic step(input bit w, input logic [DSIZE-1:0] d, input bit r, input bit rs);
    rec_t rec;
    bit   wa, ra;
    @(negedge clk);
    rst       = rs;
    bus.winc  = w;
    bus.wdata = w ? d : 'x;
    bus.rinc  = r;
    rec.rst = rs;
    rec.rd  = 1'b0;
    if (rs) begin
      model_q.delete();
    end else begin
      wa = w && (model_q.size() < DEPTH);
      ra = r && (model_q.size() > 0);
      if (ra) begin
        dat_q.push_back(model_q.pop_front());
        rec.rd = 1'b1;
      end
      if (wa) model_q.push_back(d);
    end
    rec.cnt   = model_q.size();
    rec.full  = (model_q.size() == DEPTH);
    rec.empty = (model_q.size() == 0);
    st_q.push_back(rec);
  endtask

  // Monitor: after each rising edge, compare status and read data.
  logic [DSIZE-1:0] last_rd = '0;
  always begin
    rec_t rec;
    @(posedge clk);
    if (st_q.size() > 0) begin
      rec = st_q.pop_front();
      #1;
      if (rec.rst) begin
        last_rd = '0;
      end else if (rec.rd) begin
        if (dat_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL scoreboard_underflow: no expected word at %0t", $time);
        end else begin
          last_rd = dat_q.pop_front();
        end
      end
      chk("rdata",  int'(bus.rdata),  int'(last_rd));
      chk("count",  int'(bus.count),  rec.cnt);
      chk("wfull",  int'(bus.wfull),  int'(rec.full));
      chk("rempty", int'(bus.rempty), int'(rec.empty));
    end
  end

  initial begin
    bus.winc  = 1'b0;
    bus.wdata = '0;
    bus.rinc  = 1'b0;

    // Reset, then reads on an empty FIFO must change nothing.
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);
    step(0, 0, 0, 0);
    repeat (3) step(0, 0, 1, 0);

    // Reads held high, writes every other cycle: each word passes straight through.
    for (int i = 0; i < 10; i++) begin
      step(1, 8'(8'hA0 + i), 1, 0);
      step(0, 0, 1, 0);
    end
    step(0, 0, 1, 0);

    // Fill past full: the last three writes are dropped.
    for (int i = 0; i < DEPTH + 3; i++) step(1, 8'(8'h10 + i), 0, 0);

    // Full with both requests: only the read happens.
    step(1, 8'hEE, 1, 0);
    step(1, 8'h55, 0, 0);

    // Drain from full, reads held past empty; rdata holds the last word.
    for (int i = 0; i < DEPTH + 3; i++) step(0, 0, 1, 0);

    // Empty with both requests: only the write happens, then read it out.
    step(1, 8'h77, 1, 0);
    step(0, 0, 1, 0);
    step(0, 0, 0, 0);

    // Write five, reset mid-operation, reads must see an empty FIFO.
    for (int i = 0; i < 5; i++) step(1, 8'(8'hC0 + i), 0, 0);
    step(1, 8'hFF, 1, 1);
    repeat (3) step(0, 0, 1, 0);

    // Twenty words streamed through across pointer wrap.
    for (int i = 0; i < 20; i++) step(1, 8'(8'h30 + i), (i >= 4), 0);
    repeat (DEPTH + 2) step(0, 0, 1, 0);

    // Random traffic with occasional reset.
    for (int i = 0; i < 400; i++) begin
      step(bit'($urandom_range(0, 99) < 55), 8'($urandom),
           bit'($urandom_range(0, 99) < 45), bit'($urandom_range(0, 99) < 2));
    end
    repeat (DEPTH + 2) step(0, 0, 1, 0);

    // Let the monitor consume the last record, then confirm nothing was left unread.
    repeat (3) @(posedge clk);
    #2;
    chk("pending_records", st_q.size(), 0);
    chk("pending_reads",   dat_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
